// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer: FSM states, step-table
// entry layout, note codes and the clock-divider divisors for each note.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    PAUSED
  } state_t;

  typedef struct packed {
    logic [3:0] note;
    logic [3:0] len;
  } step_t;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SO   = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;
  localparam logic [3:0] NOTE_DO2  = 4'd8;

  localparam int unsigned DIV_DO  = 95602;
  localparam int unsigned DIV_RE  = 85179;
  localparam int unsigned DIV_MI  = 75873;
  localparam int unsigned DIV_FA  = 71633;
  localparam int unsigned DIV_SO  = 63776;
  localparam int unsigned DIV_LA  = 56818;
  localparam int unsigned DIV_SI  = 50658;
  localparam int unsigned DIV_DO2 = 47801;

  // Codes 9..15 are treated as rests, so only 1..8 produce sound.
  function automatic logic is_audible(input logic [3:0] note);
    return (note >= NOTE_DO) && (note <= NOTE_DO2);
  endfunction

endpackage

// File: rtl/note_rom.sv
// Note code to Clock_divider divisor lookup. Rests and undefined codes map
// to 0 so the divider output stays quiet.
module note_rom
  import tone_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic [3:0]       note,
  output logic [DIV_W-1:0] divisor
);

  // Pure lookup; default covers rest and codes 9..15.
  always_comb begin
    divisor = '0;
    case (note)
      NOTE_REST: divisor = '0;
      NOTE_DO:   divisor = DIV_W'(DIV_DO);
      NOTE_RE:   divisor = DIV_W'(DIV_RE);
      NOTE_MI:   divisor = DIV_W'(DIV_MI);
      NOTE_FA:   divisor = DIV_W'(DIV_FA);
      NOTE_SO:   divisor = DIV_W'(DIV_SO);
      NOTE_LA:   divisor = DIV_W'(DIV_LA);
      NOTE_SI:   divisor = DIV_W'(DIV_SI);
      NOTE_DO2:  divisor = DIV_W'(DIV_DO2);
      default:   divisor = '0;
    endcase
  end

endmodule

// File: rtl/tone_sequencer.sv
// Steps through a programmable note table, holding each note for a number
// of beats, and drives the Clock_divider divisor with a one-cycle load strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stopped, tone off, waiting for play
// LOAD   | one cycle: read entry[step_idx], start note / wrap / finish
// HOLD   | note sounding, beat timer running
// PAUSED | play dropped mid-note; timer frozen, divisor held, tone off
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int NUM_STEPS = 16,
  parameter int TICK_DIV  = 12_500_000,
  parameter int DIV_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play,
  input  logic             loop,
  input  logic             restart,
  input  logic             prog_we,
  input  logic [3:0]       prog_addr,
  input  logic [3:0]       prog_note,
  input  logic [3:0]       prog_len,
  output logic [DIV_W-1:0] divisor,
  output logic             div_load,
  output logic             tone_en,
  output logic [3:0]       step_idx,
  output logic             done
);

  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       beats_q, beats_d;
  logic             audible_q, audible_d;
  logic [DIV_W-1:0] divisor_d;
  logic             div_load_d, tone_d, done_d;

  step_t            tbl [NUM_STEPS];
  step_t            cur;
  logic [DIV_W-1:0] rom_div;
  logic             tick;
  logic [IDX_W-1:0] step_inc;

  assign cur      = tbl[step_q];
  assign tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign step_inc = (step_q == IDX_W'(NUM_STEPS - 1)) ? '0 : step_q + 1'b1;
  assign step_idx = 4'(step_q);

  note_rom #(.DIV_W(DIV_W)) u_rom (
    .note    (cur.note),
    .divisor (rom_div)
  );

  // Step table: writable in any state; a rewrite of the playing step is
  // only picked up at its next LOAD because the note is latched there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) tbl[i] <= '0;
    end else if (prog_we && (int'(prog_addr) < NUM_STEPS)) begin
      tbl[IDX_W'(prog_addr)] <= '{note: prog_note, len: prog_len};
    end
  end

  // Next-state and registered-output logic; restart overrides the FSM.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    beats_d    = beats_q;
    audible_d  = audible_q;
    divisor_d  = divisor;
    div_load_d = 1'b0;
    tone_d     = tone_en;
    done_d     = 1'b0;

    if (restart) begin
      step_d  = '0;
      cnt_d   = '0;
      tone_d  = 1'b0;
      state_d = play ? LOAD : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          tone_d = 1'b0;
          if (play) state_d = LOAD;
        end
        LOAD: begin
          if (cur.len != 4'd0) begin
            divisor_d  = rom_div;
            div_load_d = 1'b1;
            audible_d  = is_audible(cur.note);
            tone_d     = is_audible(cur.note);
            beats_d    = cur.len;
            cnt_d      = '0;
            state_d    = HOLD;
          end else if (loop && (step_q != '0)) begin
            step_d = '0;
          end else begin
            // Also reached for an empty table, so looping cannot spin forever.
            tone_d  = 1'b0;
            done_d  = 1'b1;
            step_d  = '0;
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (!play) begin
            tone_d  = 1'b0;
            state_d = PAUSED;
          end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
              beats_d = beats_q - 4'd1;
              if (beats_q == 4'd1) begin
                step_d  = step_inc;
                state_d = LOAD;
              end
            end
          end
        end
        PAUSED: begin
          if (play) begin
            tone_d  = audible_q;
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      step_q    <= '0;
      cnt_q     <= '0;
      beats_q   <= '0;
      audible_q <= 1'b0;
      divisor   <= '0;
      div_load  <= 1'b0;
      tone_en   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      beats_q   <= beats_d;
      audible_q <= audible_d;
      divisor   <= divisor_d;
      div_load  <= div_load_d;
      tone_en   <= tone_d;
      done      <= done_d;
    end
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Sequences the Simple iPod tone path: steps through a programmable 16-entry note table and holds each note for a number of beats.
- For each step it drives the clock divider's DIVISOR input with the note's divisor and strobes a load pulse.
- Sits between the switch/control logic and Clock_divider. Its tone_en output gates the divided clock to the audio output.

Parameters:
- NUM_STEPS, 16, depth of the step table; step index width is $clog2(NUM_STEPS).
- TICK_DIV, 12_500_000, clk cycles per beat (0.25 s at 50 MHz); minimum value 2.
- DIV_W, 32, width of the divisor output.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- play  in  1  level; already synchronized upstream; 1 = run, 0 = pause/stop.
- loop  in  1  level; 1 = wrap to step 0 at the end marker.
- restart  in  1  single-cycle pulse; jump to step 0.
- prog_we  in  1  step-table write strobe.
- prog_addr  in  4  step-table write address.
- prog_note  in  4  note code to write.
- prog_len  in  4  beat count to write; 0 = end-of-song marker.
- divisor  out  DIV_W  divisor for Clock_divider.
- div_load  out  1  one-cycle strobe: divisor has changed.
- tone_en  out  1  1 while an audible note is sounding.
- step_idx  out  4  current step index.
- done  out  1  one-cycle pulse when a non-looping song ends.

Behaviour:
- Reset, asynchronous: state IDLE; step_idx 0; divisor 0; div_load 0; tone_en 0; done 0; beat counter 0; beats_left 0; all table entries cleared to {note 0, len 0}.
- Note codes:
  - 0 = rest.
  - 1..8 map to Do, Re, Mi, Fa, So, La, Si, Do2.
  - Divisors are 95602, 85179, 75873, 71633, 63776, 56818, 50658, 47801.
  - Codes 9..15 are treated as rest.
  - A rest outputs divisor 0 with tone_en 0.
- Table writes:
  - A write with prog_we=1 takes effect on the next edge, in any state.
  - A write to the playing step takes effect at that step's next LOAD.
  - prog_addr >= NUM_STEPS is ignored.
- Priority, highest first: reset > restart > FSM transitions.
- restart: step_idx<=0, beat counter<=0, tone_en<=0. Next state is LOAD if play=1, otherwise IDLE.
- IDLE:
  - tone_en 0.
  - play=1 sampled on an edge -> LOAD.
- LOAD lasts one cycle and reads entry[step_idx].
  - If len != 0:
    - On exit, divisor<=rom(note), div_load<=1 for exactly one cycle, tone_en<=(note in 1..8), beats_left<=len, beat counter<=0.
    - Next state HOLD.
  - If len == 0 and loop=1 and step_idx != 0: step_idx<=0, stay in LOAD.
  - If len == 0 otherwise: tone_en<=0, done<=1 for one cycle, step_idx<=0, next state IDLE.
    - This covers an empty table, which is not an infinite loop.
- Latency: play rising, sampled at edge k -> LOAD after edge k -> div_load=1 and divisor valid after edge k+1.
- HOLD:
  - The beat counter counts 0..TICK_DIV-1 and asserts tick at TICK_DIV-1, then wraps.
  - On tick, beats_left decrements.
  - On a tick with beats_left==1: step_idx<=step_idx+1 (wrapping NUM_STEPS-1 -> 0), next state LOAD.
  - HOLD therefore lasts exactly len*TICK_DIV cycles; each step occupies len*TICK_DIV+1 cycles.
- Pause:
  - play=0 in HOLD -> PAUSED, with tone_en<=0. Beat counter and beats_left freeze; divisor is held.
  - play=1 in PAUSED -> HOLD, with tone_en restored from the current note. No div_load is issued.
  - play=0 during LOAD: LOAD completes normally, then HOLD moves to PAUSED on the following edge.
- divisor holds its value in IDLE and PAUSED, with no glitch.
- div_load and done are never high in the same cycle.

Decomposition:
- tone_pkg:
  - typedef enum {IDLE, LOAD, HOLD, PAUSED} state_t.
  - typedef struct packed {logic [3:0] note; logic [3:0] len;} step_t.
  - Note-code localparams (NOTE_REST, NOTE_DO..NOTE_DO2).
  - Divisor localparams (DIV_DO=95602 ... DIV_DO2=47801).
- Sub-module note_rom: combinational, note[3:0] -> divisor[DIV_W-1:0], 0 for rest or undefined codes. Instantiated once.
- The beat timer stays inline.

Test Plan (TICK_DIV=4):
1. Reset mid-HOLD -> same cycle: divisor=0, tone_en=0, step_idx=0; reading entry 0 via play gives len 0 -> done pulse, back to IDLE.
2. Program {1,2},{3,1},{0,0}; loop=0; play=1 ->
   - div_load after 2 edges with divisor=95602, tone_en=1;
   - 9 cycles later divisor=75873;
   - 5 cycles later done=1 for one cycle, tone_en=0, step_idx=0.
3. Same program with loop=1 -> after step 1, divisor returns to 95602, no done pulse, and the pattern repeats for 3 full passes.
4. Pause 3 cycles into step 0 (play=0 for 20 cycles) -> tone_en=0 and divisor unchanged; after resume, the step ends exactly 5 HOLD cycles later; no div_load on resume.
5. Step {0,2} (rest) -> div_load=1 with divisor=0 and tone_en=0 for 8 cycles; note code 12 behaves the same.
6. restart during step 1 with play=1 -> next edge LOAD and step_idx=0; divisor=95602 one edge later. A simultaneous prog_we to entry 0 with {8,1} yields divisor 47801 instead.
